// File: rtl/pipeline_run_ctrl_if.sv
// pipeline_run_ctrl_if: host command handshake and pipeline control bundle for pipeline_run_ctrl
interface pipeline_run_ctrl_if #(
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
);
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [1:0]        i_cmd;
  logic [STEP_W-1:0] i_step_count;
  logic              i_halt;
  logic              o_cpu_en;
  logic              o_cpu_reset;
  logic              o_busy;
  logic              o_done;
  logic [1:0]        o_status;
  logic [CNT_W-1:0]  o_cycle_count;
  modport master (
    output i_cmd_valid, i_cmd, i_step_count, i_halt,
    input  o_cmd_ready, o_cpu_en, o_cpu_reset, o_busy, o_done, o_status, o_cycle_count
  );
  modport slave (
    input  i_cmd_valid, i_cmd, i_step_count, i_halt,
    output o_cmd_ready, o_cpu_en, o_cpu_reset, o_busy, o_done, o_status, o_cycle_count
  );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: run/step/drain/cpu-reset sequencer gating the MIPS pipeline enable.
// Define RUN_CTRL_BREAKPOINT_EN to add the fetch-PC breakpoint stop (status 11).
module pipeline_run_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int STEP_W       = 16,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef RUN_CTRL_BREAKPOINT_EN
  input  logic                 i_bp_set,
  input  logic [31:0]          i_bp_addr,
  input  logic [31:0]          i_fetch_pc,
`endif
  pipeline_run_ctrl_if.slave   bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, CPURST, DONE} state_t;
  state_t            state, state_n;
  logic [STEP_W-1:0] step_cnt, step_n;
  logic [DW-1:0]     drain_cnt, drain_n;
  logic              halted, halted_n, rst_ph, rst_ph_n;
  logic [1:0]        status_n;
  logic              accept, hit;
  assign accept = bus.i_cmd_valid && bus.o_cmd_ready;
`ifdef RUN_CTRL_BREAKPOINT_EN
  logic [31:0] bp_addr;
  logic        bp_armed, first;
  // the first enabled cycle after an accept ignores a match so RUN can resume from the breakpoint
  assign hit = bp_armed && !first && i_fetch_pc == bp_addr;
  always_ff @(posedge clk)
    if (reset) begin
      bp_addr  <= '0;
      bp_armed <= 1'b0;
      first    <= 1'b0;
    end else begin
      if (i_bp_set) begin
        bp_addr  <= i_bp_addr;
        bp_armed <= 1'b1;
      end else if (state == CPURST) bp_armed <= 1'b0;
      first <= accept ? 1'b1 : (bus.o_cpu_en ? 1'b0 : first);
    end
`else
  assign hit = 1'b0;
`endif
  always_comb begin
    state_n  = state;
    step_n   = step_cnt;
    drain_n  = drain_cnt;
    halted_n = halted;
    rst_ph_n = rst_ph;
    status_n = bus.o_status;
    case (state)
      IDLE: if (accept) begin
        if (bus.i_cmd == 2'b11) begin
          state_n  = CPURST;
          rst_ph_n = 1'b0;
        end else if (bus.i_cmd != 2'b00 && halted) begin
          state_n  = DONE;
          status_n = 2'b10;
        end else if (bus.i_cmd == 2'b01) state_n = RUN;
        else if (bus.i_cmd == 2'b10 && bus.i_step_count == '0) begin
          state_n  = DONE;
          status_n = 2'b01;
        end else if (bus.i_cmd == 2'b10) begin
          state_n = STEP;
          step_n  = bus.i_step_count;
        end
      end
      RUN, STEP: begin
        step_n = state == STEP ? step_cnt - STEP_W'(1) : step_cnt;
        if (bus.i_halt) begin
          state_n  = DRAIN;
          halted_n = 1'b1;
          drain_n  = DW'(DRAIN_CYCLES);
        end else if (hit) begin
          state_n  = DONE;
          status_n = 2'b11;
        end else if (state == STEP && step_cnt == STEP_W'(1)) begin
          state_n  = DONE;
          status_n = 2'b01;
        end
      end
      DRAIN: begin
        drain_n = drain_cnt - DW'(1);
        if (drain_cnt == DW'(1)) begin
          state_n  = DONE;
          status_n = 2'b10;
        end
      end
      CPURST: begin
        rst_ph_n = 1'b1;
        halted_n = 1'b0;
        status_n = 2'b00;
        state_n  = rst_ph ? DONE : CPURST;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state             <= IDLE;
      step_cnt          <= '0;
      drain_cnt         <= '0;
      halted            <= 1'b0;
      rst_ph            <= 1'b0;
      bus.o_cmd_ready   <= 1'b1;
      bus.o_cpu_en      <= 1'b0;
      bus.o_cpu_reset   <= 1'b0;
      bus.o_busy        <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_status      <= 2'b00;
      bus.o_cycle_count <= '0;
    end else begin
      state             <= state_n;
      step_cnt          <= step_n;
      drain_cnt         <= drain_n;
      halted            <= halted_n;
      rst_ph            <= rst_ph_n;
      bus.o_cmd_ready   <= state_n == IDLE;
      bus.o_cpu_en      <= state_n inside {RUN, STEP, DRAIN};
      bus.o_cpu_reset   <= state_n == CPURST;
      bus.o_busy        <= state_n != IDLE;
      bus.o_done        <= state_n == DONE;
      bus.o_status      <= status_n;
      bus.o_cycle_count <= state_n == CPURST ? '0 :
                           bus.o_cycle_count + CNT_W'(bus.o_cpu_en && !(&bus.o_cycle_count));
    end
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl: randomized self-checking bench against a per-command outcome model.
module tb_pipeline_run_ctrl;
  localparam int D = 4;
  localparam int CW = 5;
  localparam int MAXC = (1 << CW) - 1;
  localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, CRST = 2'b11;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_count = 0;
  bit m_halted = 0;
  logic [1:0] m_status = 2'b00;
  pipeline_run_ctrl_if #(.STEP_W(16), .CNT_W(CW)) bus ();
`ifdef RUN_CTRL_BREAKPOINT_EN
  logic bp_set = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] pc_base = '0;
`endif
  pipeline_run_ctrl #(.DRAIN_CYCLES(D), .STEP_W(16), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
`ifdef RUN_CTRL_BREAKPOINT_EN
    .i_bp_set(bp_set),
    .i_bp_addr(bp_addr),
    .i_fetch_pc(fetch_pc),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  // one command from accept to completion; expected outcome derived from the command rules alone
  task automatic op(input logic [1:0] c, input int n, input int halt_at, input bit hold, input int bp_at);
    int en = 0, rc = 0, cyc = 0, e_en, e_lat, e_rc = 0;
    logic [1:0] e_st;
    bit bad_busy = 0, en_at_done;
    if (c == CRST) begin e_en = 0; e_lat = 2; e_rc = 2; e_st = 2'b00; end
    else if (c == NOP) begin e_en = 0; e_lat = 0; e_st = m_status; end
    else if (m_halted) begin e_en = 0; e_lat = 0; e_st = 2'b10; end
    else if (bp_at > 0 && bp_at < halt_at && (c == RUN || bp_at <= n)) begin e_en = bp_at; e_lat = bp_at; e_st = 2'b11; end
    else if (c == RUN || (halt_at >= 1 && halt_at <= n)) begin e_en = halt_at + D; e_lat = e_en; e_st = 2'b10; end
    else begin e_en = n; e_lat = n; e_st = 2'b01; end
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd = c;
    bus.i_step_count = 16'(n);
    @(posedge clk); #1;
    bus.i_cmd = 2'($urandom_range(0, 3));
    bus.i_step_count = 16'($urandom_range(0, 20));
    while (!bus.o_done && cyc < 300) begin
      if (!bus.o_busy || bus.o_cmd_ready) bad_busy = 1;
      if (bus.o_cpu_en) en++;
      if (bus.o_cpu_reset) rc++;
      bus.i_halt = bus.o_cpu_en && (hold ? en >= halt_at : en == halt_at);
`ifdef RUN_CTRL_BREAKPOINT_EN
      if (bus.o_cpu_en) fetch_pc = pc_base + 32'(4 * (en - 1));
`endif
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_halt = 1'b0;
    en_at_done = bus.o_cpu_en;
    if (c == CRST) begin m_halted = 0; m_count = 0; end
    if (e_st == 2'b10) m_halted = 1;
    m_count = (m_count + e_en > MAXC) ? MAXC : m_count + e_en;
    m_status = e_st;
    checks++;
    if (!bus.o_done) begin errors++; $display("FAIL done_timeout cmd=%0d got no o_done within %0d cycles", c, cyc); end
    checks++;
    if (cyc !== e_lat) begin errors++; $display("FAIL latency cmd=%0d got %0d want %0d", c, cyc, e_lat); end
    checks++;
    if (en !== e_en) begin errors++; $display("FAIL enable_cycles cmd=%0d got %0d want %0d", c, en, e_en); end
    checks++;
    if (rc !== e_rc) begin errors++; $display("FAIL cpu_reset_cycles cmd=%0d got %0d want %0d", c, rc, e_rc); end
    checks++;
    if (bus.o_status !== e_st) begin errors++; $display("FAIL status cmd=%0d got %b want %b", c, bus.o_status, e_st); end
    checks++;
    if (bus.o_cycle_count !== CW'(m_count)) begin errors++; $display("FAIL cycle_count cmd=%0d got %0d want %0d", c, bus.o_cycle_count, m_count); end
    checks++;
    if (bad_busy || en_at_done) begin errors++; $display("FAIL busy_flags cmd=%0d bad_busy=%0d en_at_done=%0d want 0 0", c, bad_busy, en_at_done); end
    @(posedge clk); #1;
    checks++;
    if ({bus.o_cmd_ready, bus.o_busy, bus.o_done, bus.o_cpu_en} !== 4'b1000) begin
      errors++;
      $display("FAIL back_to_idle cmd=%0d got rdy/busy/done/en=%b want 1000", c, {bus.o_cmd_ready, bus.o_busy, bus.o_done, bus.o_cpu_en});
    end
  endtask
  task automatic test_nop();
    bit bad = 0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd = NOP;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ({bus.o_cmd_ready, bus.o_busy, bus.o_done, bus.o_cpu_en} !== 4'b1000 || bus.o_status !== m_status || bus.o_cycle_count !== CW'(m_count)) bad = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL nop got activity or state change want none"); end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = NOP;
    bus.i_step_count = '0;
    bus.i_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_cmd_ready, bus.o_busy, bus.o_cpu_en, bus.o_cpu_reset, bus.o_done, bus.o_status, bus.o_cycle_count} !== {5'b10000, 2'b00, CW'(0)}) begin
      errors++;
      $display("FAIL reset_values got %b want %b", {bus.o_cmd_ready, bus.o_busy, bus.o_cpu_en, bus.o_cpu_reset, bus.o_done, bus.o_status, bus.o_cycle_count}, {5'b10000, 2'b00, CW'(0)});
    end
    reset = 1'b0;
    m_count = 0; m_halted = 0; m_status = 2'b00;
  endtask
  task automatic test_step();
    op(STEP, 3, 1000, 0, 0);
  endtask
  task automatic test_run_halt();
    op(CRST, 0, 1000, 0, 0);
    op(RUN, 0, 10, 0, 0);
  endtask
  task automatic test_halted_rerun();
    op(RUN, 0, 5, 0, 0);
    op(STEP, 4, 1000, 0, 0);
    op(CRST, 0, 1000, 0, 0);
  endtask
  task automatic test_step_zero();
    op(STEP, 0, 1000, 0, 0);
    test_nop();
  endtask
  task automatic test_step_halt_and_reset();
    int en = 0, cyc = 0;
    op(STEP, 5, 5, 0, 0);
    op(CRST, 0, 1000, 0, 0);
    op(RUN, 0, 3, 1, 0);
    op(CRST, 0, 1000, 0, 0);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd = STEP;
    bus.i_step_count = 16'd5;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    while (cyc < 50) begin
      if (bus.o_cpu_en) en++;
      if (en == 6) break;
      bus.i_halt = bus.o_cpu_en && en == 5;
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_halt = 1'b0;
    checks++;
    if (en != 6) begin errors++; $display("FAIL reach_drain got %0d enabled cycles want 6", en); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({bus.o_cmd_ready, bus.o_busy, bus.o_cpu_en, bus.o_cpu_reset, bus.o_done, bus.o_status, bus.o_cycle_count} !== {5'b10000, 2'b00, CW'(0)}) begin
      errors++;
      $display("FAIL mid_drain_reset got %b want %b", {bus.o_cmd_ready, bus.o_busy, bus.o_cpu_en, bus.o_cpu_reset, bus.o_done, bus.o_status, bus.o_cycle_count}, {5'b10000, 2'b00, CW'(0)});
    end
    m_count = 0; m_halted = 0; m_status = 2'b00;
    op(RUN, 0, 2, 0, 0);
  endtask
  task automatic test_saturation();
    op(CRST, 0, 1000, 0, 0);
    op(RUN, 0, 30, 0, 0);
    op(CRST, 0, 1000, 0, 0);
    op(STEP, 20, 1000, 0, 0);
    op(STEP, 15, 1000, 0, 0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int r = $urandom_range(0, 9);
      if (r == 0) test_nop();
      else op(r <= 2 ? CRST : (r <= 5 ? RUN : STEP), $urandom_range(0, 10), $urandom_range(1, 12), 1'($urandom_range(0, 1)), 0);
    end
  endtask
`ifdef RUN_CTRL_BREAKPOINT_EN
  task automatic test_breakpoint();
    op(CRST, 0, 1000, 0, 0);
    bp_addr = 32'h40;
    bp_set = 1'b1;
    @(posedge clk); #1;
    bp_set = 1'b0;
    pc_base = 32'h0;
    op(RUN, 0, 1000, 0, 17);
    pc_base = 32'h40;
    op(RUN, 0, 5, 0, 0);
    op(CRST, 0, 1000, 0, 0);
    bp_set = 1'b1;
    @(posedge clk); #1;
    bp_set = 1'b0;
    pc_base = 32'h0;
    op(RUN, 0, 17, 0, 17);
    op(CRST, 0, 1000, 0, 0);
    bp_set = 1'b1;
    @(posedge clk); #1;
    bp_set = 1'b0;
    op(STEP, 20, 1000, 0, 17);
  endtask
`endif
  initial begin
    test_reset();
    test_step();
    test_run_halt();
    test_halted_rerun();
    test_step_zero();
    test_step_halt_and_reset();
    test_saturation();
    test_random();
`ifdef RUN_CTRL_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
Execution controller for the 5-stage MIPS pipeline. It gates pipeline advancement through a global clock-enable, and it can pulse a CPU-local reset. It sequences three operations: free-running execution until HALT, single/multi-cycle stepping, and post-HALT drain so in-flight instructions retire before completion is reported. It sits between the host/debug command interface and the pipeline top level; the pipeline's `halt` output feeds back into it.

Parameters:
- DRAIN_CYCLES, 4: cycles `o_cpu_en` stays high after HALT is seen (EX/MEM/WB retire); must be ≥1.
- STEP_W, 16: width of the step-count operand.
- CNT_W, 32: width of the executed-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command strobe.
- o_cmd_ready  out  1  controller can accept a command.
- i_cmd  in  2  command code: 00 NOP, 01 RUN, 10 STEP, 11 CPU_RESET.
- i_step_count  in  STEP_W  number of enable cycles for STEP; sampled at accept.
- i_halt  in  1  HALT detected by the pipeline.
- o_cpu_en  out  1  pipeline advance enable (all stage registers and PC).
- o_cpu_reset  out  1  CPU-local synchronous reset.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle completion pulse.
- o_status  out  2  stop reason: 00 none, 01 step exhausted, 10 halted, 11 breakpoint.
- o_cycle_count  out  CNT_W  count of cycles with `o_cpu_en`=1, saturating.

Behaviour:
- Reset values:
  - State IDLE.
  - `o_cmd_ready`=1.
  - `o_cpu_en`, `o_cpu_reset`, `o_busy`, `o_done` all 0.
  - `o_status`=00, `o_cycle_count`=0, halted flag=0, step counter=0.
  - `reset` asserted mid-operation aborts immediately to these values.
- Outputs are registered. A command is accepted on a cycle with `i_cmd_valid` & `o_cmd_ready`.
- `o_cmd_ready`=1 only in IDLE. `o_busy` = !IDLE.
- States: IDLE, RUN, STEP, DRAIN, CPURST, DONE.
- IDLE:
  - NOP is accepted with no effect and no `o_done`.
  - RUN → RUN.
  - STEP with `i_step_count`=0 → DONE, status 01, zero enable cycles.
  - STEP with `i_step_count`>0 → STEP, counter loaded with `i_step_count`.
  - CPU_RESET → CPURST.
  - If the halted flag is set, RUN and STEP go directly to DONE with status 10 and zero enable cycles.
- RUN:
  - `o_cpu_en`=1 every cycle.
  - `i_halt` sampled high on a cycle with `o_cpu_en`=1 → DRAIN, halted flag set, drain counter = DRAIN_CYCLES.
- STEP:
  - `o_cpu_en`=1 for exactly the loaded count of cycles; the counter decrements each enabled cycle.
  - When the count reaches 0 → DONE, status 01.
  - `i_halt` takes priority when it coincides with the final step cycle → DRAIN, status 10.
- DRAIN:
  - `o_cpu_en`=1 for DRAIN_CYCLES cycles, then → DONE, status 10.
  - `i_halt` is ignored in DRAIN.
- CPURST:
  - `o_cpu_reset`=1 and `o_cpu_en`=0 for exactly 2 cycles.
  - Clears the halted flag, `o_cycle_count`, and status → 00.
  - Then → DONE.
- DONE: `o_done`=1 for one cycle, `o_cpu_en`=0, → IDLE.
- Status holds its value until the next completion or CPU_RESET.
- `o_cycle_count` increments on each `o_cpu_en`=1 cycle and saturates at all-ones; no wrap.
- `o_cpu_en` is never high in IDLE, DONE or CPURST.

Optional Feature:
- Macro: RUN_CTRL_BREAKPOINT_EN.
- When defined, three extra inputs are added:
  - `i_bp_set` (1): loads the breakpoint register from `i_bp_addr`; accepted in any state.
  - `i_bp_addr` (32): breakpoint address.
  - `i_fetch_pc` (32): current fetch PC.
- Also adds a breakpoint-armed bit, set by `i_bp_set` and cleared by CPU_RESET.
- In RUN or STEP, an armed breakpoint matching `i_fetch_pc`==`bp_addr` on an enabled cycle → DONE with status 11. There is no drain, and `o_cpu_en` drops the next cycle.
- A breakpoint match on the same cycle as `i_halt`: halt wins.
- The first enabled cycle after a command accept ignores a breakpoint match, so a RUN from the breakpoint address can resume.
- When the macro is undefined, the ports are absent and status 11 is never produced.

Test Plan:
1. Reset, then STEP with count 3 → `o_cpu_en` high exactly 3 cycles, `o_done` pulse, status 01, `o_cycle_count`=3, `o_cmd_ready` back to 1.
2. RUN; assert `i_halt` on the 10th enabled cycle → 4 further enabled cycles (DRAIN_CYCLES=4), `o_done`, status 10, `o_cycle_count`=14.
3. After scenario 2, issue RUN → `o_done` after 1 cycle, zero enable cycles; then CPU_RESET → `o_cpu_reset` high 2 cycles, count 0, status 00.
4. STEP with count 0 → `o_done` on the cycle after accept, `o_cpu_en` never high, status 01; `i_cmd_valid` during busy is not accepted.
5. STEP with count 5 and `i_halt` on the 5th enabled cycle → DRAIN 4 cycles, status 10, count 9. Assert `reset` mid-DRAIN in a rerun → all outputs return to reset values the next cycle.
6. (RUN_CTRL_BREAKPOINT_EN) Set bp=0x40; RUN with `i_fetch_pc` reaching 0x40 on the 17th cycle → stop, status 11, no drain. RUN again from 0x40 → no immediate stop.
